// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings for the multiply/divide unit
package muldiv_pkg;
    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;
endpackage

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - one shift-add / restoring-divide iteration per enable
module muldiv_datapath #(
    parameter int WIDTH = muldiv_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_a_mag,
    input  logic [WIDTH-1:0] i_b_mag,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_shift
);
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    // Multiply: {acc,shift} shifts right, adding opnd when the shifted-out bit is set.
    // Divide: the dividend shifts out of the top of shift into acc; quotient bits enter at bit 0.
    assign w_sum    = {1'b0, r_acc} + (r_shift[0] ? {1'b0, r_opnd} : '0);
    assign w_rem_sh = {r_acc, r_shift[WIDTH-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_opnd});
    assign w_diff   = w_rem_sh[WIDTH-1:0] - r_opnd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc   <= '0;
            r_shift <= '0;
            r_opnd  <= '0;
        end else if (i_load) begin
            r_acc   <= '0;
            r_shift <= i_a_mag;
            r_opnd  <= i_b_mag;
        end else if (i_step) begin
            if (i_is_div) begin
                r_acc   <= w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
                r_shift <= {r_shift[WIDTH-2:0], w_ge};
            end else begin
                r_acc   <= w_sum[WIDTH:1];
                r_shift <= {w_sum[0], r_shift[WIDTH-1:1]};
            end
        end
    end

    assign o_acc   = r_acc;
    assign o_shift = r_shift;
endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning HI/LO
module muldiv_unit #(
    parameter int WIDTH = muldiv_pkg::WIDTH,
    parameter int CNT_W = muldiv_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import muldiv_pkg::*;

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;

    logic               w_signed;
    logic               w_load;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_acc;
    logic [WIDTH-1:0]   w_shift;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;

    assign w_signed = (op == OP_MULT) || (op == OP_DIV);
    assign w_load   = (r_state == IDLE) && start;
    assign w_a_mag  = (w_signed && a[WIDTH-1]) ? -a : a;
    assign w_b_mag  = (w_signed && b[WIDTH-1]) ? -b : b;

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_step   (r_state == RUN),
        .i_is_div (r_is_div),
        .i_a_mag  (w_a_mag),
        .i_b_mag  (w_b_mag),
        .o_acc    (w_acc),
        .o_shift  (w_shift)
    );

    // Sign fixup on the unsigned core result; remainder follows the dividend's sign.
    assign w_prod     = {w_acc, w_shift};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_q_fix    = r_neg_q ? -w_shift : w_shift;
    assign w_r_fix    = r_neg_r ? -w_acc : w_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_is_div <= op[1];
                        r_neg_q  <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_r  <= w_signed && a[WIDTH-1];
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                        r_state  <= RUN;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= FIX;
                end
                FIX: begin
                    if (r_is_div) begin
                        hi <= w_r_fix;
                        lo <= w_q_fix;
                    end else begin
                        {hi, lo} <= w_prod_fix;
                    end
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
